multiport_regfile: RTL

- Parametrised successor to the single-write / dual-read base register file.
- Adds: configurable width, depth, read-port and write-port counts; asynchronous reset of all storage; optional hard-wired zero register; same-cycle write-to-read bypass; optional registered read; and a per-register busy scoreboard used by the pipeline control to detect pending writes.
- Sits between decode (read, issue) and writeback (write, busy clear) in the pipelined CPU datapath.

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_read_port.sv | 62 ++++++
 rtl/multiport_regfile.sv | 90 +++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared helpers and defaults for the multi-port register file.
// Includes the packed-port slice macro used by the register file modules.
package rf_pkg;

    localparam int unsigned RF_DW    = 32;
    localparam int unsigned RF_DEPTH = 32;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

`ifndef RF_SLICE
`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

// File: rtl/rf_read_port.sv
// One read port: address mux, same-cycle write bypass, zero-register override,
// and an optional output register.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned DW       = RF_DW,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned NW       = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned RD_REG   = 0,
    localparam int unsigned AW      = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        regs [DEPTH],
    input  logic [DEPTH-1:0]     busy,
    input  logic [NW-1:0]        we,
    input  logic [NW*AW-1:0]     waddr,
    input  logic [NW*DW-1:0]     wdata,
    input  logic [AW-1:0]        raddr,
    output logic [DW-1:0]        rdata,
    output logic                 rbusy
);

    logic [DW-1:0] sel_data;
    logic          sel_busy;
    logic [DW-1:0] rdata_q;
    logic          rbusy_q;

    // Later ports override earlier ones so the highest-index writer is forwarded.
    always_comb begin
        sel_data = regs[raddr];
        sel_busy = busy[raddr];
        if (BYPASS != 0) begin
            for (int w = 0; w < int'(NW); w++) begin
                if (we[w] && (`RF_SLICE(waddr, w, AW) == raddr)) begin
                    sel_data = `RF_SLICE(wdata, w, DW);
                    sel_busy = 1'b0;
                end
            end
        end
        if ((ZERO_REG != 0) && (raddr == '0)) begin
            sel_data = '0;
            sel_busy = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            rbusy_q <= 1'b0;
        end else begin
            rdata_q <= sel_data;
            rbusy_q <= sel_busy;
        end
    end

    assign rdata = (RD_REG != 0) ? rdata_q : sel_data;
    assign rbusy = (RD_REG != 0) ? rbusy_q : sel_busy;

endmodule

// File: rtl/multiport_regfile.sv
// Parametrised multi-port register file with write arbitration, optional
// zero register, bypass, registered read and a pending-write scoreboard.
module multiport_regfile
    import rf_pkg::*;
#(
    parameter int unsigned DW       = RF_DW,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned NR       = 2,
    parameter int unsigned NW       = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned RD_REG   = 0,
    localparam int unsigned AW      = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NW-1:0]        we,
    input  logic [NW*AW-1:0]     waddr,
    input  logic [NW*DW-1:0]     wdata,
    input  logic [NR*AW-1:0]     raddr,
    output logic [NR*DW-1:0]     rdata,
    output logic [NR-1:0]        rbusy,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_addr,
    output logic [DEPTH-1:0]     busy_vec
);

    logic [DW-1:0]    regs [DEPTH];
    logic [NW-1:0]    wr_ok;
    logic [DEPTH-1:0] busy_nxt;

    // Register 0 swallows writes when hard-wired to zero.
    always_comb begin
        wr_ok = '0;
        for (int w = 0; w < int'(NW); w++) begin
            wr_ok[w] = we[w] && !((ZERO_REG != 0) && (`RF_SLICE(waddr, w, AW) == '0));
        end
    end

    // Ascending port order makes the highest-index writer win on a conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs[AW'(r)] <= '0;
            end
        end else begin
            for (int w = 0; w < int'(NW); w++) begin
                if (wr_ok[w]) regs[`RF_SLICE(waddr, w, AW)] <= `RF_SLICE(wdata, w, DW);
            end
        end
    end

    // Issue is applied after retirement so a new producer keeps the register busy.
    always_comb begin
        busy_nxt = busy_vec;
        for (int w = 0; w < int'(NW); w++) begin
            if (we[w]) busy_nxt[`RF_SLICE(waddr, w, AW)] = 1'b0;
        end
        if (iss_valid) busy_nxt[iss_addr] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_vec <= '0;
        else     busy_vec <= busy_nxt;
    end

    for (genvar j = 0; j < int'(NR); j++) begin : g_rd
        rf_read_port #(
            .DW       (DW),
            .DEPTH    (DEPTH),
            .NW       (NW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS),
            .RD_REG   (RD_REG)
        ) u_port (
            .clk   (clk),
            .rst   (rst),
            .regs  (regs),
            .busy  (busy_vec),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .raddr (raddr[j*AW +: AW]),
            .rdata (rdata[j*DW +: DW]),
            .rbusy (rbusy[j])
        );
    end

endmodule
